// File: rtl/series_engine.sv
// Fixed-point power-series evaluator: 1 + sum s_k * x^k / k!, iterating
// term <- term * x * (1/k) until the term drops below a threshold or the cap is hit.
module series_engine #(
  parameter int W       = 16,
  parameter int FRAC    = 8,
  parameter int N_TERMS = 16,
  parameter int CW      = $clog2(N_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x_in,
  input  logic [W-1:0]  thr_in,
  input  logic          alt,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [CW-1:0] term_count,
  output logic          ovf
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MUL_X = 3'd1;
  localparam logic [2:0] MUL_C = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] ACC   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;

  logic [2:0]    state;
  logic [W-1:0]  x_r, thr_r, term, ans;
  logic          alt_r, ovf_run;
  logic [CW-1:0] k;

  // Reciprocal ROM indexed directly by k; out-of-range slots read as zero.
  logic [W-1:0] coef_rom [0:(1<<CW)-1];
  for (genvar g = 0; g < (1 << CW); g++) begin : g_rom
    if (g >= 1 && g <= N_TERMS) begin : g_val
      assign coef_rom[g] = W'((2 ** FRAC) / g);
    end else begin : g_zero
      assign coef_rom[g] = '0;
    end
  end

  logic [2*W-1:0] prod_x, prod_c;
  logic [W:0]     sum;
  logic           add_mode, acc_sat;
  logic [W-1:0]   ans_next;

  always_comb begin
    prod_x   = {{W{1'b0}}, term} * {{W{1'b0}}, x_r};
    prod_c   = {{W{1'b0}}, term} * {{W{1'b0}}, coef_rom[k]};
    sum      = {1'b0, ans} + {1'b0, term};
    add_mode = !alt_r || !k[0];
    acc_sat  = 1'b0;
    ans_next = ans;
    if (add_mode) begin
      acc_sat  = sum[W];
      ans_next = sum[W] ? '1 : sum[W-1:0];
    end else begin
      acc_sat  = term > ans;
      ans_next = (term > ans) ? '0 : ans - term;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{prod_c[2*W-1:W+FRAC], prod_c[FRAC-1:0], prod_x[FRAC-1:0]};

  // Results are registered on entry to DONE so they are valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x_r        <= '0;
      thr_r      <= '0;
      alt_r      <= 1'b0;
      term       <= '0;
      ans        <= '0;
      k          <= '0;
      ovf_run    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      term_count <= '0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_r     <= x_in;
            thr_r   <= thr_in;
            alt_r   <= alt;
            term    <= ONE;
            ans     <= ONE;
            k       <= CW'(1);
            ovf_run <= 1'b0;
            busy    <= 1'b1;
            state   <= MUL_X;
          end
        end
        MUL_X: begin
          if (|prod_x[2*W-1:W+FRAC]) begin
            term    <= '1;
            ovf_run <= 1'b1;
          end else begin
            term <= prod_x[W+FRAC-1:FRAC];
          end
          state <= MUL_C;
        end
        MUL_C: begin
          term  <= prod_c[W+FRAC-1:FRAC];
          state <= CHECK;
        end
        CHECK: begin
          if (term < thr_r) begin
            done       <= 1'b1;
            result     <= ans;
            term_count <= k - CW'(1);
            ovf        <= ovf_run;
            state      <= DONE;
          end else begin
            state <= ACC;
          end
        end
        ACC: begin
          ans     <= ans_next;
          ovf_run <= ovf_run | acc_sat;
          k       <= k + CW'(1);
          if (k == CW'(N_TERMS)) begin
            done       <= 1'b1;
            result     <= ans_next;
            term_count <= k;
            ovf        <= ovf_run | acc_sat;
            state      <= DONE;
          end else begin
            state <= MUL_X;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_series_engine.sv
// Directed bench for series_engine: expected results queued at start, checked at done.
module tb_series_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x_in, thr_in;
  logic        alt;
  logic        busy, done, ovf;
  logic [15:0] result;
  logic [4:0]  term_count;

  int tests = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  cnt;
    logic        ovf;
    int          edges;
  } exp_t;

  exp_t sb[$];

  series_engine #(.W(16), .FRAC(8), .N_TERMS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .thr_in(thr_in),
    .alt(alt), .busy(busy), .done(done), .result(result),
    .term_count(term_count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] thr, input logic a,
                     input int pulse_at, input exp_t e);
    exp_t got;
    int edges;
    sb.push_back(e);
    @(negedge clk);
    x_in = x; thr_in = thr; alt = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && edges < 200) begin
      @(negedge clk);
      edges++;
      start = (edges == pulse_at);
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("done_edge", edges, got.edges);
      check("result", {16'd0, result}, {16'd0, got.res});
      check("term_count", {27'd0, term_count}, {27'd0, got.cnt});
      check("ovf", {31'd0, ovf}, {31'd0, got.ovf});
      check("busy_with_done", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("done_pulse_end", {31'd0, done}, 32'd0);
    check("busy_end", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x_in = '0; thr_in = '0; alt = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_count", {27'd0, term_count}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    run(16'h0100, 16'h0001, 1'b0, -1, '{16'h02B5, 5'd5, 1'b0, 23});
    run(16'h0100, 16'h0001, 1'b1, -1, '{16'h005F, 5'd5, 1'b0, 23});
    run(16'h0000, 16'h0001, 1'b0, -1, '{16'h0100, 5'd0, 1'b0, 3});
    run(16'h0080, 16'h0000, 1'b0, 10, '{16'h01A5, 5'd16, 1'b0, 64});
    @(negedge clk);
    check("no_queued_start", {31'd0, busy}, 32'd0);
    run(16'hFF00, 16'h0001, 1'b0, -1, '{16'hFFFF, 5'd16, 1'b1, 64});
    run(16'h0100, 16'h0001, 1'b0, -1, '{16'h02B5, 5'd5, 1'b0, 23});

    // Abort a run in its MUL_C cycle with a start coinciding with reset.
    @(negedge clk);
    x_in = 16'h0100; thr_in = 16'h0001; alt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    check("abort_count", {27'd0, term_count}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("abort_start_ignored", {31'd0, busy}, 32'd0);

    run(16'h0100, 16'h0001, 1'b0, -1, '{16'h02B5, 5'd5, 1'b0, 23});

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
